// File: rtl/dct_sequencer_if.sv
// Bus bundle between the DCT sequencer, its upstream/downstream ports and the PE array.
interface dct_sequencer_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RES_W  = 64
);
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_ready;
    logic                     arr_clr;
    logic signed [DATA_W-1:0] arr_x;
    logic signed [DATA_W-1:0] arr_w0;
    logic signed [DATA_W-1:0] arr_w1;
    logic signed [DATA_W-1:0] arr_w2;
    logic signed [DATA_W-1:0] arr_w3;
    logic signed [RES_W-1:0]  arr_res0;
    logic signed [RES_W-1:0]  arr_res1;
    logic signed [RES_W-1:0]  arr_res2;
    logic signed [RES_W-1:0]  arr_res3;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [RES_W-1:0]  y0;
    logic signed [RES_W-1:0]  y1;
    logic signed [RES_W-1:0]  y2;
    logic signed [RES_W-1:0]  y3;
    logic                     busy;
    logic [15:0]              blk_cnt;

    // Sequencer side
    modport master (
        input  in_valid, in_data, arr_res0, arr_res1, arr_res2, arr_res3, out_ready,
        output in_ready, arr_clr, arr_x, arr_w0, arr_w1, arr_w2, arr_w3,
        output out_valid, y0, y1, y2, y3, busy, blk_cnt
    );

    // Upstream source, downstream sink and PE array side
    modport slave (
        output in_valid, in_data, arr_res0, arr_res1, arr_res2, arr_res3, out_ready,
        input  in_ready, arr_clr, arr_x, arr_w0, arr_w1, arr_w2, arr_w3,
        input  out_valid, y0, y1, y2, y3, busy, blk_cnt
    );
endinterface

// File: rtl/dct_sequencer.sv
// Controller for the 4-PE 1-D DCT systolic array: load 4 samples, clear, feed skewed
// samples/coefficients, capture Y0..Y3 and hand them downstream.
module dct_sequencer #(
    parameter int unsigned N      = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RES_W  = 64
) (
    input logic             clk,
    input logic             rst,
    dct_sequencer_if.master bus
);
    typedef enum logic [2:0] {StLoad, StClear, StFeed, StCapture, StOut} state_e;

    state_e                   state_q, state_d;
    logic [1:0]               idx_q, idx_d;
    logic [2:0]               t_q, t_d;
    logic signed [DATA_W-1:0] smp_q [N];
    logic signed [RES_W-1:0]  y_q [N];
    logic [15:0]              blk_cnt_q;
    logic signed [DATA_W-1:0] x_c;
    logic signed [DATA_W-1:0] w_c [N];

    // Q8 basis ROM C[k][n], sign-extended to DATA_W
    function automatic logic signed [DATA_W-1:0] coef(input logic [1:0] k, input logic [1:0] n);
        logic signed [9:0] c;
        c = '0;
        case ({k, n})
            4'h0, 4'h1, 4'h2, 4'h3: c = 10'sd128;
            4'h4:                   c = 10'sd167;
            4'h5:                   c = 10'sd69;
            4'h6:                   c = -10'sd69;
            4'h7:                   c = -10'sd167;
            4'h8, 4'hb:             c = 10'sd128;
            4'h9, 4'ha:             c = -10'sd128;
            4'hc:                   c = 10'sd69;
            4'hd:                   c = -10'sd167;
            4'he:                   c = 10'sd167;
            4'hf:                   c = -10'sd69;
            default:                c = '0;
        endcase
        return {{(DATA_W-10){c[9]}}, c};
    endfunction

    // Next-state logic for the FSM, sample index and feed counter
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        t_d     = t_q;
        unique case (state_q)
            StLoad: begin
                if (bus.in_valid) begin
                    idx_d = idx_q + 2'd1;  // wraps to 0 after the 4th sample
                    if (idx_q == 2'd3) state_d = StClear;
                end
            end
            StClear: begin
                t_d     = 3'd0;
                state_d = StFeed;
            end
            StFeed: begin
                if (t_q == 3'd6) begin
                    t_d     = 3'd0;
                    state_d = StCapture;
                end else begin
                    t_d = t_q + 3'd1;
                end
            end
            StCapture: state_d = StOut;
            StOut:     if (bus.out_ready) state_d = StLoad;
            default:   state_d = StLoad;
        endcase
    end

    // Array drive: sample to PE0, coefficient to PE k delayed k cycles; zero outside FEED
    always_comb begin
        x_c = '0;
        for (int k = 0; k < int'(N); k++) w_c[k] = '0;
        if (state_q == StFeed) begin
            if (t_q < 3'd4) x_c = smp_q[t_q[1:0]];
            for (int k = 0; k < int'(N); k++) begin
                if (t_q >= 3'(k) && (t_q - 3'(k)) <= 3'd3) begin
                    w_c[k] = coef(2'(k), 2'(t_q - 3'(k)));
                end
            end
        end
    end

    // Control state, results and block counter with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StLoad;
            idx_q     <= 2'd0;
            t_q       <= 3'd0;
            blk_cnt_q <= 16'd0;
            for (int k = 0; k < int'(N); k++) y_q[k] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            t_q     <= t_d;
            if (state_q == StCapture) begin
                y_q[0]    <= bus.arr_res0;
                y_q[1]    <= bus.arr_res1;
                y_q[2]    <= bus.arr_res2;
                y_q[3]    <= bus.arr_res3;
                blk_cnt_q <= blk_cnt_q + 16'd1;
            end
        end
    end

    // Sample buffer; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (state_q == StLoad && bus.in_valid) smp_q[idx_q] <= bus.in_data;
    end

    assign bus.in_ready  = (state_q == StLoad);
    assign bus.busy      = (state_q != StLoad);
    assign bus.arr_clr   = (state_q == StClear);
    assign bus.out_valid = (state_q == StOut);
    assign bus.arr_x     = x_c;
    assign bus.arr_w0    = w_c[0];
    assign bus.arr_w1    = w_c[1];
    assign bus.arr_w2    = w_c[2];
    assign bus.arr_w3    = w_c[3];
    assign bus.y0        = y_q[0];
    assign bus.y1        = y_q[1];
    assign bus.y2        = y_q[2];
    assign bus.y3        = y_q[3];
    assign bus.blk_cnt   = blk_cnt_q;
endmodule

// File: tb/tb_dct_sequencer.sv
// Self-checking bench for dct_sequencer with a behavioural 4-PE systolic array model.
module tb_dct_sequencer;
    logic clk = 1'b0;
    logic rst;

    dct_sequencer_if #(.DATA_W(32), .RES_W(64)) bus ();

    dct_sequencer #(.N(4), .DATA_W(32), .RES_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic signed [63:0] y0;
        logic signed [63:0] y1;
        logic signed [63:0] y2;
        logic signed [63:0] y3;
        logic [15:0]        blk;
    } exp_t;

    int   n_checks = 0;
    int   n_errors = 0;
    int   coef_tab [4][4] = '{'{128, 128, 128, 128}, '{167, 69, -69, -167},
                              '{128, -128, -128, 128}, '{69, -167, 167, -69}};
    int   smp [4];
    exp_t sb [$];
    int   exp_blk = 0;
    int   clr_cnt = 0;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // PE array model: each PE MACs its north/west inputs at the edge and forwards x south
    logic signed [31:0] pe_x [4];
    logic signed [31:0] pe_w [4];
    logic signed [31:0] xq [4];
    logic signed [63:0] acc [4];
    assign pe_x[0] = bus.arr_x;
    assign pe_x[1] = xq[0];
    assign pe_x[2] = xq[1];
    assign pe_x[3] = xq[2];
    assign pe_w[0] = bus.arr_w0;
    assign pe_w[1] = bus.arr_w1;
    assign pe_w[2] = bus.arr_w2;
    assign pe_w[3] = bus.arr_w3;
    assign bus.arr_res0 = acc[0];
    assign bus.arr_res1 = acc[1];
    assign bus.arr_res2 = acc[2];
    assign bus.arr_res3 = acc[3];

    // Array registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                xq[k]  <= '0;
                acc[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                xq[k]  <= pe_x[k];
                acc[k] <= bus.arr_clr ? 64'sd0
                        : acc[k] + 64'(longint'(pe_x[k]) * longint'(pe_w[k]));
            end
        end
    end

    // Count clear pulses
    always @(negedge clk) if (bus.arr_clr) clr_cnt++;

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 1);
        check({tag, "_busy"}, 64'(bus.busy), 0);
        check({tag, "_out_valid"}, 64'(bus.out_valid), 0);
        check({tag, "_arr_clr"}, 64'(bus.arr_clr), 0);
        check({tag, "_arr_x"}, bus.arr_x, 0);
        check({tag, "_arr_w0"}, bus.arr_w0, 0);
        check({tag, "_arr_w1"}, bus.arr_w1, 0);
        check({tag, "_arr_w2"}, bus.arr_w2, 0);
        check({tag, "_arr_w3"}, bus.arr_w3, 0);
    endtask

    // Drive smp[] upstream (call right after a negedge); returns at the CLEAR-cycle negedge
    task automatic send_block(input int max_gap, input bit push);
        exp_t e;
        longint y [4];
        int guard;
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(max_gap, 0)) @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = smp[i];
            guard = 0;
            while (!bus.in_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) check("in_ready_timeout", 0, 1);
            @(posedge clk);
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
        if (push) begin
            for (int k = 0; k < 4; k++) begin
                y[k] = 0;
                for (int n = 0; n < 4; n++) y[k] += longint'(coef_tab[k][n]) * smp[n];
            end
            exp_blk = (exp_blk + 1) & 16'hffff;
            e.y0 = y[0];
            e.y1 = y[1];
            e.y2 = y[2];
            e.y3 = y[3];
            e.blk = 16'(exp_blk);
            sb.push_back(e);
        end
    endtask

    // Check the CLEAR cycle and t=0..6 of FEED
    task automatic trace_feed(input int t_stop);
        int ex;
        check("clear_pulse", 64'(bus.arr_clr), 1);
        check("clear_in_ready", 64'(bus.in_ready), 0);
        check("clear_busy", 64'(bus.busy), 1);
        for (int t = 0; t <= t_stop; t++) begin
            @(negedge clk);
            ex = (t < 4) ? smp[t] : 0;
            check($sformatf("feed_x_t%0d", t), bus.arr_x, ex);
            for (int k = 0; k < 4; k++) begin
                ex = (t - k >= 0 && t - k <= 3) ? coef_tab[k][t-k] : 0;
                check($sformatf("feed_w%0d_t%0d", k, t),
                      (k == 0) ? bus.arr_w0 : (k == 1) ? bus.arr_w1 :
                      (k == 2) ? bus.arr_w2 : bus.arr_w3, ex);
            end
            check($sformatf("feed_in_ready_t%0d", t), 64'(bus.in_ready), 0);
        end
    endtask

    // Wait for the result, compare with the scoreboard, then backpressure and release
    task automatic receive(input int hold);
        exp_t e;
        int lat;
        lat = 8;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 40);
        check("out_latency", lat, 10);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check("y0", bus.y0, e.y0);
            check("y1", bus.y1, e.y1);
            check("y2", bus.y2, e.y2);
            check("y3", bus.y3, e.y3);
            check("blk_cnt", 64'(bus.blk_cnt), 64'(e.blk));
            for (int c = 0; c < hold; c++) begin
                @(negedge clk);
                check("hold_out_valid", 64'(bus.out_valid), 1);
                check("hold_in_ready", 64'(bus.in_ready), 0);
                check("hold_y0", bus.y0, e.y0);
                check("hold_y1", bus.y1, e.y1);
            end
            check("hold_y3_end", bus.y3, e.y3);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("release_out_valid", 64'(bus.out_valid), 0);
        check("release_in_ready", 64'(bus.in_ready), 1);
        check("release_busy", 64'(bus.busy), 0);
    endtask

    task automatic run_block(input int max_gap, input int hold);
        int clr0;
        clr0 = clr_cnt;
        send_block(max_gap, 1'b1);
        trace_feed(6);
        receive(hold);
        check("clr_pulses", clr_cnt - clr0, 1);
    endtask

    initial begin
        int ov_cnt;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        check("reset_y0", bus.y0, 0);
        check("reset_y1", bus.y1, 0);
        check("reset_y2", bus.y2, 0);
        check("reset_y3", bus.y3, 0);
        check("reset_blk_cnt", 64'(bus.blk_cnt), 0);
        rst = 1'b0;
        @(negedge clk);
        check_idle("post_reset");

        smp = '{1, 1, 1, 1};
        run_block(0, 0);
        smp = '{1, 2, 3, 4};
        run_block(3, 20);
        smp = '{-4, -3, -2, -1};
        run_block(0, 2);

        // Reset while FEED is at t=3: block discarded, counters and results cleared
        smp = '{5, 6, 7, 8};
        send_block(1, 1'b0);
        trace_feed(3);
        rst = 1'b1;
        #1;
        exp_blk = 0;
        check_idle("midrst");
        check("midrst_y0", bus.y0, 0);
        check("midrst_y1", bus.y1, 0);
        check("midrst_blk_cnt", 64'(bus.blk_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        ov_cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.out_valid) ov_cnt++;
        end
        check("midrst_no_out_valid", ov_cnt, 0);

        smp = '{2, 2, 2, 2};
        run_block(2, 1);
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end
endmodule
